// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer in front of a single-port data memory.
// Round-robin on contention, bounded bus lock for read-modify-write, registered read returns.
module dmem_arbiter #(
    parameter int W        = 8,
    parameter int A        = 8,
    parameter int LOCK_MAX = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Req0,
    input  logic         Req1,
    input  logic         We0,
    input  logic         We1,
    input  logic         Lock0,
    input  logic         Lock1,
    input  logic [A-1:0] Addr0,
    input  logic [A-1:0] Addr1,
    input  logic [W-1:0] Wdata0,
    input  logic [W-1:0] Wdata1,
    output logic         Gnt0,
    output logic         Gnt1,
    output logic [W-1:0] Rdata0,
    output logic [W-1:0] Rdata1,
    output logic         RdValid0,
    output logic         RdValid1,
    output logic         LockErr,
    output logic         MemWriteEn,
    output logic [A-1:0] MemAddress,
    output logic [W-1:0] MemDataIn,
    input  logic [W-1:0] MemDataOut
);

    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic          last_reg, last_next;
    logic [CW-1:0] lock_cnt_reg, lock_cnt_next;
    logic          lock_err_reg, lock_err_next;

    logic [1:0] gnt_vec;
    logic [1:0] we_vec;

    assign we_vec = {We1, We0};

    // Grants are suppressed for the whole time reset is asserted, not just at the edge.
    always_comb begin
        gnt_vec = 2'b00;
        if (Reset) begin
            case (state_reg)
                IDLE: begin
                    if (Req0 && Req1) begin
                        if (last_reg) gnt_vec = 2'b01;
                        else          gnt_vec = 2'b10;
                    end else begin
                        gnt_vec = {Req1, Req0};
                    end
                end
                OWN0:    gnt_vec = {1'b0, Req0};
                OWN1:    gnt_vec = {Req1, 1'b0};
                default: gnt_vec = 2'b00;
            endcase
        end
    end

    assign Gnt0 = gnt_vec[0];
    assign Gnt1 = gnt_vec[1];

    always_comb begin
        MemWriteEn = 1'b0;
        MemAddress = '0;
        MemDataIn  = '0;
        if (gnt_vec[0]) begin
            MemWriteEn = We0;
            MemAddress = Addr0;
            MemDataIn  = Wdata0;
        end else if (gnt_vec[1]) begin
            MemWriteEn = We1;
            MemAddress = Addr1;
            MemDataIn  = Wdata1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        last_next     = last_reg;
        lock_cnt_next = lock_cnt_reg;
        lock_err_next = lock_err_reg;

        if (gnt_vec[0])      last_next = 1'b0;
        else if (gnt_vec[1]) last_next = 1'b1;

        case (state_reg)
            IDLE: begin
                if (gnt_vec[0] && Lock0) begin
                    state_next    = OWN0;
                    lock_cnt_next = '0;
                end else if (gnt_vec[1] && Lock1) begin
                    state_next    = OWN1;
                    lock_cnt_next = '0;
                end
            end
            OWN0: begin
                if (gnt_vec[0] && !Lock0) begin
                    state_next    = IDLE;
                    lock_cnt_next = '0;
                end else if (lock_cnt_reg == CNT_LAST) begin
                    // Forced release: marking the owner as last winner hands the next contention to the other side.
                    state_next    = IDLE;
                    lock_cnt_next = '0;
                    lock_err_next = 1'b1;
                    last_next     = 1'b0;
                end else begin
                    lock_cnt_next = lock_cnt_reg + 1'b1;
                end
            end
            OWN1: begin
                if (gnt_vec[1] && !Lock1) begin
                    state_next    = IDLE;
                    lock_cnt_next = '0;
                end else if (lock_cnt_reg == CNT_LAST) begin
                    state_next    = IDLE;
                    lock_cnt_next = '0;
                    lock_err_next = 1'b1;
                    last_next     = 1'b1;
                end else begin
                    lock_cnt_next = lock_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next    = IDLE;
                lock_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg    <= IDLE;
            last_reg     <= 1'b1;
            lock_cnt_reg <= '0;
            lock_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            last_reg     <= last_next;
            lock_cnt_reg <= lock_cnt_next;
            lock_err_reg <= lock_err_next;
        end
    end

    assign LockErr = lock_err_reg;

    // Per-requester read return registers; the non-granted side holds its data.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [W-1:0] rdata_reg;
        logic         rd_valid_reg;

        always_ff @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
                rdata_reg    <= '0;
                rd_valid_reg <= 1'b0;
            end else begin
                rd_valid_reg <= gnt_vec[gi] && !we_vec[gi];
                if (gnt_vec[gi] && !we_vec[gi]) begin
                    rdata_reg <= MemDataOut;
                end
            end
        end
    end

    assign Rdata0   = g_port[0].rdata_reg;
    assign Rdata1   = g_port[1].rdata_reg;
    assign RdValid0 = g_port[0].rd_valid_reg;
    assign RdValid1 = g_port[1].rd_valid_reg;

endmodule
